// File: rtl/sequence_scan_scheduler.sv
// Round-robin scheduler that serialises one requester's word into a shared "1011" detector
// and counts the detector's matches. Define SCAN_STATS_EN to add per-requester cumulative totals.
module sequence_scan_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*WORD_W-1:0]   word_in,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        seq_bit,
  output logic                        det_reset,
  input  logic                        detector_out,
  output logic                        done,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] done_id,
  output logic [CNT_W-1:0]            match_count,
  output logic                        busy
`ifdef SCAN_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]       total_count
`endif
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_acc;
  logic                prev_shift_q;
  logic                det_reset_q;

  logic [NUM_REQ-1:0]  grant_d;
  logic                seq_d, det_reset_d, done_d, busy_d;
  logic [ID_W-1:0]     done_id_d;
  logic [CNT_W-1:0]    match_count_d;

  logic                found;
  logic [ID_W-1:0]     pick;
  logic [WORD_W-1:0]   pick_word;
  int unsigned         idx;

  // Round-robin search starting at the requester after the last one served
  always_comb begin
    found     = 1'b0;
    pick      = '0;
    pick_word = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_q) + k) % NUM_REQ;
      if (!found && req[ID_W'(idx)]) begin
        found     = 1'b1;
        pick      = ID_W'(idx);
        pick_word = word_in[idx*WORD_W +: WORD_W];
      end
    end
  end

  // Only detector outputs that follow a SHIFT cycle belong to the current word
  always_comb begin
    cnt_acc = cnt_q;
    if (prev_shift_q && detector_out && (cnt_q != '1)) begin
      cnt_acc = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    bit_d         = bit_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_acc;
    grant_d       = grant;
    seq_d         = 1'b0;
    det_reset_d   = 1'b0;
    done_d        = 1'b0;
    done_id_d     = '0;
    match_count_d = '0;
    busy_d        = 1'b1;

    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        busy_d  = found;
        if (found) begin
          state_d       = S_CLEAR;
          word_d        = pick_word;
          owner_d       = pick;
          rr_d          = (pick == ID_W'(NUM_REQ - 1)) ? '0 : pick + ID_W'(1);
          grant_d[pick] = 1'b1;
          det_reset_d   = 1'b1;
          cnt_d         = '0;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
        bit_d   = '0;
        seq_d   = word_q[WORD_W-1];
        word_d  = word_q << 1;
      end
      S_SHIFT: begin
        if (bit_q == BIT_W'(WORD_W - 1)) begin
          state_d = S_DRAIN;
        end else begin
          seq_d  = word_q[WORD_W-1];
          word_d = word_q << 1;
          bit_d  = bit_q + BIT_W'(1);
        end
      end
      S_DRAIN: begin
        state_d       = S_DONE;
        done_d        = 1'b1;
        done_id_d     = owner_q;
        match_count_d = cnt_acc;
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      bit_q        <= '0;
      rr_q         <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      prev_shift_q <= 1'b0;
      det_reset_q  <= 1'b0;
      grant        <= '0;
      seq_bit      <= 1'b0;
      done         <= 1'b0;
      done_id      <= '0;
      match_count  <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      bit_q        <= bit_d;
      rr_q         <= rr_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      prev_shift_q <= (state_q == S_SHIFT);
      det_reset_q  <= det_reset_d;
      grant        <= grant_d;
      seq_bit      <= seq_d;
      done         <= done_d;
      done_id      <= done_id_d;
      match_count  <= match_count_d;
      busy         <= busy_d;
    end
  end

  // The detector is held in reset for every cycle our own reset is high
  assign det_reset = det_reset_q | reset;

`ifdef SCAN_STATS_EN
  logic [15:0] tot_q [NUM_REQ];
  logic [15:0] tot_d [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      tot_d[i] = tot_q[i];
      if ((state_q == S_DONE) && (owner_q == ID_W'(i))) begin
        tot_d[i] = ((17'(tot_q[i]) + 17'(match_count)) > 17'h0FFFF) ?
                   16'hFFFF : (tot_q[i] + 16'(match_count));
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (reset) tot_q[i] <= '0;
      else       tot_q[i] <= tot_d[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_total
    assign total_count[g*16 +: 16] = tot_q[g];
  end
`endif

endmodule
